// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle controller: state enum, ALU codes,
// datapath mux selects and RV32 major opcodes.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_EXECU,
    S_ALUWB,
    S_BRANCH,
    S_JAL,
    S_JALR,
    S_ILLEGAL
  } state_e;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_ONE  = 4'b1000;
  localparam logic [3:0] ALU_ZERO = 4'b1001;
  localparam logic [3:0] ALU_CTZ  = 4'b1010;
  localparam logic [3:0] ALU_CLZ  = 4'b1011;
  localparam logic [3:0] ALU_CPOP = 4'b1100;

  localparam logic [1:0] SRC_A_PC    = 2'b00;
  localparam logic [1:0] SRC_A_OLDPC = 2'b01;
  localparam logic [1:0] SRC_A_RS1   = 2'b10;
  localparam logic [1:0] SRC_A_ZERO  = 2'b11;

  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_IMM  = 2'b01;
  localparam logic [1:0] SRC_B_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_LIVE   = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic ADR_PC     = 1'b0;
  localparam logic ADR_ALUOUT = 1'b1;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_ZBB  = 7'b0110000;

endpackage

// File: rtl/mc_control_fsm_if.sv
// Instruction fields, flags and control outputs between controller and datapath.
// master = controller side, slave = datapath/instruction-register side.
interface mc_control_fsm_if;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rs2_field;
  logic       mem_ready;
  logic       zero, less, greater, u_less, u_greater;
  logic [3:0] alu_control;
  logic       add_sub_mode;
  logic [1:0] alu_src_a, alu_src_b, result_src;
  logic [2:0] imm_src;
  logic       adr_src;
  logic       ir_write, pc_write, mem_write, reg_write;
  logic       illegal_instr;

  modport master (
    input  opcode, funct3, funct7, rs2_field, mem_ready,
    input  zero, less, greater, u_less, u_greater,
    output alu_control, add_sub_mode, alu_src_a, alu_src_b, result_src,
    output imm_src, adr_src, ir_write, pc_write, mem_write, reg_write, illegal_instr
  );

  modport slave (
    output opcode, funct3, funct7, rs2_field, mem_ready,
    output zero, less, greater, u_less, u_greater,
    input  alu_control, add_sub_mode, alu_src_a, alu_src_b, result_src,
    input  imm_src, adr_src, ir_write, pc_write, mem_write, reg_write, illegal_instr
  );
endinterface

// File: rtl/alu_decoder.sv
// Combinational funct3/funct7/rs2 decode to ALU code for OP and OP-IMM; zero latency.
// No backpressure; illegal flags encodings the ALU cannot execute.
module alu_decoder
  import ctrl_pkg::*;
(
  input  logic       is_imm,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic [4:0] rs2_field,
  input  logic       less,
  input  logic       u_less,
  output logic [3:0] alu_control,
  output logic       add_sub_mode,
  output logic       illegal
);

  always_comb begin
    alu_control = ALU_ADD;
    illegal     = 1'b0;
    // R-type only tolerates funct7=0100000 on the SUB and SRA slots
    if (!is_imm && funct7 != F7_BASE &&
        !(funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101)))
      illegal = 1'b1;
    case (funct3)
      3'b000: alu_control = (!is_imm && funct7 == F7_ALT) ? ALU_SUB : ALU_ADD;
      3'b001: begin
        if (funct7 == F7_BASE) begin
          alu_control = ALU_SLL;
        end else if (is_imm && funct7 == F7_ZBB) begin
          case (rs2_field)
            5'b00000: alu_control = ALU_CLZ;
            5'b00001: alu_control = ALU_CTZ;
            5'b00010: alu_control = ALU_CPOP;
            default:  illegal     = 1'b1;
          endcase
        end else begin
          illegal = 1'b1;
        end
      end
      3'b010: alu_control = less   ? ALU_ONE : ALU_ZERO;
      3'b011: alu_control = u_less ? ALU_ONE : ALU_ZERO;
      3'b100: alu_control = ALU_XOR;
      3'b101: begin
        if (funct7 == F7_BASE)     alu_control = ALU_SRL;
        else if (funct7 == F7_ALT) alu_control = ALU_SRA;
        else                       illegal     = 1'b1;
      end
      3'b110: alu_control = ALU_OR;
      3'b111: alu_control = ALU_AND;
    endcase
  end

  assign add_sub_mode = (alu_control == ALU_SUB);

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle RV32I+Zbb controller; outputs are combinational from state_q and fields.
// FETCH/MEMREAD/MEMWRITE stall on mem_ready; reset forces FETCH with all writes off.
module mc_control_fsm
  import ctrl_pkg::*;
(
  input logic               clk,
  input logic               rst,
  mc_control_fsm_if.master  bus
);

  state_e     state_q, state_d;
  logic [3:0] dec_alu;
  logic       dec_mode, dec_illegal;
  logic       taken;
  logic       unused_flags;

  assign unused_flags = bus.greater ^ bus.u_greater;

  alu_decoder u_alu_decoder (
    .is_imm       (state_q == S_EXECI),
    .funct3       (bus.funct3),
    .funct7       (bus.funct7),
    .rs2_field    (bus.rs2_field),
    .less         (bus.less),
    .u_less       (bus.u_less),
    .alu_control  (dec_alu),
    .add_sub_mode (dec_mode),
    .illegal      (dec_illegal)
  );

  always_comb begin
    taken = 1'b0;
    case (bus.funct3)
      3'b000:  taken = bus.zero;
      3'b001:  taken = !bus.zero;
      3'b100:  taken = bus.less;
      3'b101:  taken = !bus.less;
      3'b110:  taken = bus.u_less;
      3'b111:  taken = !bus.u_less;
      default: taken = 1'b0;
    endcase
  end

  // Defaults equal the reset-time output values; states only override.
  always_comb begin
    state_d           = state_q;
    bus.alu_control   = ALU_ADD;
    bus.add_sub_mode  = 1'b0;
    bus.alu_src_a     = SRC_A_PC;
    bus.alu_src_b     = SRC_B_FOUR;
    bus.result_src    = RES_LIVE;
    bus.imm_src       = IMM_I;
    bus.adr_src       = ADR_PC;
    bus.ir_write      = 1'b0;
    bus.pc_write      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.reg_write     = 1'b0;
    bus.illegal_instr = 1'b0;
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          bus.ir_write = bus.mem_ready;
          bus.pc_write = bus.mem_ready;
          if (bus.mem_ready) state_d = S_DECODE;
        end
        S_DECODE: begin
          bus.alu_src_a = SRC_A_OLDPC;
          bus.alu_src_b = SRC_B_IMM;
          bus.imm_src   = IMM_B;
          case (bus.opcode)
            OP_LOAD, OP_STORE: state_d = S_MEMADR;
            OP_OP:             state_d = S_EXECR;
            OP_OPIMM:          state_d = S_EXECI;
            OP_LUI, OP_AUIPC:  state_d = S_EXECU;
            OP_BRANCH:         state_d = S_BRANCH;
            OP_JAL:            state_d = S_JAL;
            OP_JALR:           state_d = S_JALR;
            default:           state_d = S_ILLEGAL;
          endcase
        end
        S_MEMADR: begin
          bus.alu_src_a = SRC_A_RS1;
          bus.alu_src_b = SRC_B_IMM;
          bus.imm_src   = (bus.opcode == OP_STORE) ? IMM_S : IMM_I;
          state_d       = (bus.opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
        end
        S_MEMREAD: begin
          bus.adr_src = ADR_ALUOUT;
          if (bus.mem_ready) state_d = S_MEMWB;
        end
        S_MEMWB: begin
          bus.result_src = RES_RDATA;
          bus.reg_write  = 1'b1;
          state_d        = S_FETCH;
        end
        S_MEMWRITE: begin
          bus.adr_src   = ADR_ALUOUT;
          bus.mem_write = 1'b1;
          if (bus.mem_ready) state_d = S_FETCH;
        end
        S_EXECR, S_EXECI: begin
          bus.alu_src_a    = SRC_A_RS1;
          bus.alu_src_b    = (state_q == S_EXECI) ? SRC_B_IMM : SRC_B_RS2;
          bus.alu_control  = dec_alu;
          bus.add_sub_mode = dec_mode;
          state_d          = dec_illegal ? S_ILLEGAL : S_ALUWB;
        end
        S_EXECU: begin
          bus.alu_src_a = (bus.opcode == OP_LUI) ? SRC_A_ZERO : SRC_A_OLDPC;
          bus.alu_src_b = SRC_B_IMM;
          bus.imm_src   = IMM_U;
          state_d       = S_ALUWB;
        end
        S_ALUWB: begin
          bus.result_src = RES_ALUOUT;
          bus.reg_write  = 1'b1;
          state_d        = S_FETCH;
        end
        S_BRANCH: begin
          bus.alu_src_a    = SRC_A_RS1;
          bus.alu_src_b    = SRC_B_RS2;
          bus.imm_src      = IMM_B;
          bus.alu_control  = ALU_SUB;
          bus.add_sub_mode = 1'b1;
          bus.result_src   = RES_ALUOUT;
          if (bus.funct3 == 3'b010 || bus.funct3 == 3'b011) begin
            state_d = S_ILLEGAL;
          end else begin
            bus.pc_write = taken;
            state_d      = S_FETCH;
          end
        end
        S_JAL: begin
          bus.alu_src_a  = SRC_A_OLDPC;
          bus.result_src = RES_ALUOUT;
          bus.pc_write   = 1'b1;
          state_d        = S_ALUWB;
        end
        S_JALR: begin
          bus.alu_src_a  = SRC_A_RS1;
          bus.alu_src_b  = SRC_B_IMM;
          bus.pc_write   = 1'b1;
          state_d        = S_ALUWB;
        end
        S_ILLEGAL: begin
          bus.illegal_instr = 1'b1;
          state_d           = S_FETCH;
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Builds the expected per-cycle control trace of each instruction from its class
// and compares it with the controller outputs, one instruction after another.
module tb_mc_control_fsm;

  localparam logic [6:0] OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011, OP_OP = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_BR = 7'b1100011, OP_JAL = 7'b1101111, OP_JALR = 7'b1100111;
  localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_AND = 4'd2, A_OR = 4'd3, A_XOR = 4'd4;
  localparam logic [3:0] A_SLL = 4'd5, A_SRL = 4'd6, A_SRA = 4'd7, A_ONE = 4'd8, A_ZERO = 4'd9;
  localparam logic [3:0] A_CTZ = 4'd10, A_CLZ = 4'd11, A_CPOP = 4'd12;
  // ctl = {ir,pc,memw,regw,illegal,adr_src,result_src}; dp = {alu,mode,src_a,src_b,imm}
  localparam logic [7:0]  CM_ALL = 8'hFF, CM_W = 8'hF8, CM_WA = 8'hFC, CM_WR = 8'hFB;
  localparam logic [11:0] DM_ALL = 12'hFFF, DM_NOIMM = 12'hFF8;

  typedef struct {
    logic        mr;
    logic [4:0]  fl;   // {zero, less, greater, u_less, u_greater}
    logic [7:0]  ce, cm;
    logic [11:0] de, dm;
  } step_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  mc_control_fsm_if bus ();
  mc_control_fsm dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  step_t plan[$];
  int nvec = 0, nerr = 0, ninstr = 0;

  function automatic logic [4:0] flg(input int fl);
    return (fl < 0) ? 5'($urandom) : 5'(fl);
  endfunction

  task automatic add(input logic mr, input logic [4:0] f, input logic [7:0] ce, input logic [7:0] cm,
                     input logic [11:0] de, input logic [11:0] dm);
    step_t s;
    s.mr = mr; s.fl = f; s.ce = ce; s.cm = cm; s.de = de; s.dm = dm;
    plan.push_back(s);
  endtask

  // Mnemonic-level view of OP / OP-IMM: which operation, or not executable.
  task automatic alu_ref(input bit imm, input logic [2:0] f3, input logic [6:0] f7, input logic [4:0] rs2,
                         input bit lt, input bit ult, output logic [3:0] code, output bit ill);
    bit base, alt;
    base = (f7 == 7'h00);
    alt  = (f7 == 7'h20);
    code = A_ADD;
    ill  = 1'b0;
    if (!imm && !base && !(alt && (f3 == 3'd0 || f3 == 3'd5))) ill = 1'b1;
    if      (f3 == 3'd0) code = (!imm && alt) ? A_SUB : A_ADD;
    else if (f3 == 3'd2) code = lt  ? A_ONE : A_ZERO;
    else if (f3 == 3'd3) code = ult ? A_ONE : A_ZERO;
    else if (f3 == 3'd4) code = A_XOR;
    else if (f3 == 3'd6) code = A_OR;
    else if (f3 == 3'd7) code = A_AND;
    else if (f3 == 3'd5) begin
      if (base) code = A_SRL; else if (alt) code = A_SRA; else ill = 1'b1;
    end else begin
      if (base) code = A_SLL;
      else if (imm && f7 == 7'h30 && rs2 == 5'd0) code = A_CLZ;
      else if (imm && f7 == 7'h30 && rs2 == 5'd1) code = A_CTZ;
      else if (imm && f7 == 7'h30 && rs2 == 5'd2) code = A_CPOP;
      else ill = 1'b1;
    end
  endtask

  task automatic build(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7, input logic [4:0] rs2,
                       input int fw, input int mw, input int fl);
    logic [4:0] f;
    logic [3:0] code;
    bit ill, tk, imm;
    plan.delete();
    for (int i = 0; i <= fw; i++)
      add(i == fw, flg(fl), (i == fw) ? 8'hC2 : 8'h02, CM_ALL, {A_ADD, 1'b0, 2'b00, 2'b10, 3'b000}, DM_NOIMM);
    add(1'($urandom), flg(fl), 8'h00, CM_W, {A_ADD, 1'b0, 2'b01, 2'b01, 3'b010}, DM_ALL);
    if (op == OP_LOAD || op == OP_STORE) begin
      add(1'($urandom), flg(fl), 8'h00, CM_W,
          {A_ADD, 1'b0, 2'b10, 2'b01, (op == OP_STORE) ? 3'b001 : 3'b000}, DM_ALL);
      for (int i = 0; i <= mw; i++)
        add(i == mw, flg(fl), (op == OP_STORE) ? 8'h24 : 8'h04, CM_WA, 12'h000, 12'h000);
      if (op == OP_LOAD) add(1'($urandom), flg(fl), 8'h11, CM_WR, 12'h000, 12'h000);
    end else if (op == OP_OP || op == OP_IMM) begin
      imm = (op == OP_IMM);
      f = flg(fl);
      alu_ref(imm, f3, f7, rs2, f[3], f[1], code, ill);
      add(1'($urandom), f, 8'h00, CM_W, {code, code == A_SUB, 2'b10, imm ? 2'b01 : 2'b00, 3'b000},
          (imm ? DM_ALL : DM_NOIMM) & (ill ? 12'h07F : 12'hFFF));
      if (ill) add(1'($urandom), flg(fl), 8'h08, CM_W, 12'h000, 12'h000);
      else     add(1'($urandom), flg(fl), 8'h10, CM_WR, 12'h000, 12'h000);
    end else if (op == OP_LUI || op == OP_AUIPC) begin
      add(1'($urandom), flg(fl), 8'h00, CM_W,
          {A_ADD, 1'b0, (op == OP_LUI) ? 2'b11 : 2'b01, 2'b01, 3'b100}, DM_ALL);
      add(1'($urandom), flg(fl), 8'h10, CM_WR, 12'h000, 12'h000);
    end else if (op == OP_BR) begin
      f = flg(fl);
      ill = (f3 == 3'd2 || f3 == 3'd3);
      case (f3[2:1])
        2'b00:   tk = f[4];
        2'b10:   tk = f[3];
        default: tk = f[1];
      endcase
      tk = (tk ^ f3[0]) && !ill;
      add(1'($urandom), f, {1'b0, tk, 6'b000000}, CM_WR, {A_SUB, 1'b1, 2'b10, 2'b00, 3'b000}, DM_NOIMM);
      if (ill) add(1'($urandom), flg(fl), 8'h08, CM_W, 12'h000, 12'h000);
    end else if (op == OP_JAL || op == OP_JALR) begin
      if (op == OP_JAL)
        add(1'($urandom), flg(fl), 8'h40, CM_WR, {A_ADD, 1'b0, 2'b01, 2'b10, 3'b000}, DM_NOIMM);
      else
        add(1'($urandom), flg(fl), 8'h42, CM_WR, {A_ADD, 1'b0, 2'b10, 2'b01, 3'b000}, DM_ALL);
      add(1'($urandom), flg(fl), 8'h10, CM_WR, 12'h000, 12'h000);
    end else begin
      add(1'($urandom), flg(fl), 8'h08, CM_W, 12'h000, 12'h000);
    end
  endtask

  task automatic check(input int step, input step_t s);
    logic [7:0]  oc;
    logic [11:0] od;
    oc = {bus.ir_write, bus.pc_write, bus.mem_write, bus.reg_write, bus.illegal_instr, bus.adr_src, bus.result_src};
    od = {bus.alu_control, bus.add_sub_mode, bus.alu_src_a, bus.alu_src_b, bus.imm_src};
    nvec++;
    assert ((oc & s.cm) === (s.ce & s.cm)) else begin
      nerr++;
      $error("FAIL ctl instr=%0d step=%0d observed=%h expected=%h", ninstr, step, oc & s.cm, s.ce & s.cm);
    end
    nvec++;
    assert ((od & s.dm) === (s.de & s.dm)) else begin
      nerr++;
      $error("FAIL dp instr=%0d step=%0d observed=%h expected=%h", ninstr, step, od & s.dm, s.de & s.dm);
    end
  endtask

  task automatic run_plan();
    foreach (plan[i]) begin
      bus.mem_ready = plan[i].mr;
      {bus.zero, bus.less, bus.greater, bus.u_less, bus.u_greater} = plan[i].fl;
      #3;
      check(i, plan[i]);
      @(posedge clk);
      #1;
    end
    ninstr++;
  endtask

  task automatic instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7, input logic [4:0] rs2,
                       input int fw, input int mw, input int fl);
    bus.opcode = op; bus.funct3 = f3; bus.funct7 = f7; bus.rs2_field = rs2;
    build(op, f3, f7, rs2, fw, mw, fl);
    run_plan();
  endtask

  task automatic chk_reset();
    step_t s;
    s.mr = 1'b0; s.fl = 5'd0;
    s.ce = 8'h02; s.cm = CM_ALL;
    s.de = {A_ADD, 1'b0, 2'b00, 2'b10, 3'b000}; s.dm = DM_ALL;
    #3;
    check(-1, s);
  endtask

  initial begin
    bus.opcode = '0; bus.funct3 = '0; bus.funct7 = '0; bus.rs2_field = '0;
    bus.mem_ready = 1'b0;
    {bus.zero, bus.less, bus.greater, bus.u_less, bus.u_greater} = 5'd0;
    #1;
    chk_reset();
    @(posedge clk); #1;
    rst = 1'b0;

    // LW stalled in MEMREAD, then reset lands mid-access
    bus.opcode = OP_LOAD; bus.funct3 = 3'b010; bus.funct7 = '0; bus.rs2_field = '0;
    build(OP_LOAD, 3'b010, 7'h00, 5'd0, 0, 5, -1);
    while (plan.size() > 5) void'(plan.pop_back());
    run_plan();
    rst = 1'b1; bus.mem_ready = 1'b0;
    chk_reset();
    @(posedge clk); #1;
    chk_reset();
    @(posedge clk); #1;
    rst = 1'b0;

    instr(OP_OP, 3'b000, 7'h00, 5'd2, 0, 0, -1);         // ADD x3,x1,x2
    instr(OP_OP, 3'b000, 7'h20, 5'd2, 0, 0, -1);         // SUB
    instr(OP_BR, 3'b100, 7'h00, 5'd2, 0, 0, 5'b01000);   // BLT taken
    instr(OP_BR, 3'b100, 7'h00, 5'd2, 0, 0, 5'b00000);   // BLT not taken
    instr(OP_LOAD, 3'b010, 7'h00, 5'd0, 0, 2, -1);       // LW, two wait cycles
    instr(OP_IMM, 3'b001, 7'h30, 5'd2, 0, 0, -1);        // CPOP
    instr(OP_IMM, 3'b010, 7'h00, 5'd5, 0, 0, 5'b01000);  // SLTI, less
    instr(OP_IMM, 3'b010, 7'h00, 5'd5, 0, 0, 5'b00000);  // SLTI, not less
    instr(7'b0000000, 3'b000, 7'h00, 5'd0, 0, 0, -1);    // illegal opcode
    instr(OP_IMM, 3'b001, 7'h30, 5'd3, 0, 0, -1);        // Zbb form, bad rs2
    instr(OP_STORE, 3'b010, 7'h00, 5'd0, 1, 1, -1);
    instr(OP_JALR, 3'b000, 7'h00, 5'd0, 0, 0, -1);
    instr(OP_BR, 3'b011, 7'h00, 5'd0, 0, 0, -1);

    for (int n = 0; n < 300; n++) begin
      logic [6:0] op, f7;
      logic [4:0] rs2;
      logic [6:0] ops [9];
      ops = '{OP_LOAD, OP_STORE, OP_OP, OP_IMM, OP_LUI, OP_AUIPC, OP_BR, OP_JAL, OP_JALR};
      if ($urandom_range(0, 9) == 0) op = 7'($urandom);
      else                           op = ops[$urandom_range(0, 8)];
      case ($urandom_range(0, 3))
        0:       f7 = 7'h00;
        1:       f7 = 7'h20;
        2:       f7 = 7'h30;
        default: f7 = 7'($urandom);
      endcase
      rs2 = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 3)) : 5'($urandom);
      instr(op, 3'($urandom), f7, rs2, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
